// File: rtl/ahb_bus_arbiter_if.sv
// Bus-side signal bundle for the AHB arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requests and the shared HTRANS/HBURST/HREADY/HRESP.
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = $clog2(NUM_MASTERS)
);
  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic                   HRESP;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MW-1:0]          HMASTER;
  logic                   HMASTLOCK;

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    output HGRANT, HMASTER, HMASTLOCK
  );

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    input  HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Burst-aware round-robin AHB arbiter.
// A granted fixed-length burst keeps the bus until its last beat unless the
// slave answers ERROR; undefined-length (INCR) bursts keep it while the owner
// holds its request. Optional locked transfers are enabled with the macro
// AHB_ARB_LOCK_EN; without it HLOCK is ignored and HMASTLOCK is tied low.
//
// state      | meaning
// ST_ARB     | grant may move every cycle
// ST_BURST   | fixed-length burst in progress, grant frozen until last beat
// ST_INCR    | undefined-length burst, grant frozen while owner requests
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_bus_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_INCR  = 2'd2;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] BU_SINGLE = 3'b000;
  localparam logic [2:0] BU_INCR   = 3'b001;

  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);

  logic [1:0]             state, state_nxt;
  logic [3:0]             cnt, cnt_nxt, load_cnt;
  logic [MW-1:0]          grant_idx, hmaster_q, rr_ptr, next_idx;
  logic [NUM_MASTERS-1:0] hgrant_q;
  logic                   burst_start, arb_base, arb_ok, owner_req, lock_hold;

  assign owner_req   = bus.HBUSREQ[hmaster_q];
  // A NON_SEQ that opens a multi-beat burst must not lose the grant on the
  // same edge the burst is loaded, otherwise the first beats would be split.
  assign burst_start = (bus.HTRANS == TR_NONSEQ) && (bus.HBURST != BU_SINGLE);

  // Beats remaining after the NON_SEQ, decoded from HBURST.
  always_comb begin
    case (bus.HBURST)
      3'b010, 3'b011: load_cnt = 4'd3;
      3'b100, 3'b101: load_cnt = 4'd7;
      3'b110, 3'b111: load_cnt = 4'd15;
      default:        load_cnt = 4'd0;
    endcase
  end

  // Arbitration point: where the grant is allowed to move this cycle.
  always_comb begin
    case (state)
      ST_BURST: arb_base = bus.HREADY && (bus.HTRANS == TR_SEQ) && (cnt == 4'd1);
      ST_INCR:  arb_base = !owner_req;
      default:  arb_base = 1'b1;
    endcase
    arb_ok = arb_base && !burst_start && !lock_hold;
  end

  // Round-robin scan starting just after the last owner; parks on the default.
  always_comb begin
    int   j;
    logic found;
    logic [MW-1:0] cand;
    next_idx = DEF_IDX;
    found    = 1'b0;
    j        = 0;
    cand     = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      cand = MW'(j);
      if (!found && bus.HBUSREQ[cand]) begin
        next_idx = cand;
        found    = 1'b1;
      end
    end
  end

  // Burst tracking: load on NON_SEQ, count SEQ beats, ERROR aborts.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (bus.HRESP) begin
      state_nxt = ST_ARB;
      cnt_nxt   = 4'd0;
    end else if (bus.HREADY) begin
      if (bus.HTRANS == TR_NONSEQ) begin
        cnt_nxt = load_cnt;
        if (load_cnt != 4'd0)             state_nxt = ST_BURST;
        else if (bus.HBURST == BU_INCR)   state_nxt = ST_INCR;
        else                              state_nxt = ST_ARB;
      end else begin
        case (state)
          ST_BURST: begin
            if (bus.HTRANS == TR_SEQ) begin
              if (cnt <= 4'd1) begin
                cnt_nxt   = 4'd0;
                state_nxt = ST_ARB;
              end else begin
                cnt_nxt = cnt - 4'd1;
              end
            end else if (bus.HTRANS == TR_IDLE) begin
              cnt_nxt   = 4'd0;
              state_nxt = ST_ARB;
            end
          end
          ST_INCR: begin
            if (bus.HTRANS == TR_IDLE) state_nxt = ST_ARB;
          end
          default: ;
        endcase
      end
    end
  end

  // Burst state and beat counter registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_ARB;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Grant register: moves only at an arbitration point, always one-hot.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_idx <= DEF_IDX;
      hgrant_q  <= DEF_GRANT;
    end else if (arb_ok) begin
      grant_idx <= next_idx;
      hgrant_q  <= NUM_MASTERS'(1) << next_idx;
    end
  end

  // Address-phase owner follows the grant on HREADY edges; pointer tracks it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hmaster_q <= DEF_IDX;
      rr_ptr    <= DEF_IDX;
    end else if (bus.HREADY) begin
      hmaster_q <= grant_idx;
      if (grant_idx != hmaster_q) rr_ptr <= grant_idx;
    end
  end

`ifdef AHB_ARB_LOCK_EN
  logic grant_lock, mastlock_q;

  assign lock_hold = bus.HLOCK[grant_idx];

  // Remember whether the newly granted master asked for a lock, and expose it
  // once that master owns the address phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_lock <= 1'b0;
      mastlock_q <= 1'b0;
    end else begin
      if (arb_ok)     grant_lock <= bus.HLOCK[next_idx];
      if (bus.HREADY) mastlock_q <= grant_lock;
    end
  end

  assign bus.HMASTLOCK = mastlock_q;
`else
  assign lock_hold     = 1'b0;
  assign bus.HMASTLOCK = 1'b0;
`endif

  assign bus.HGRANT  = hgrant_q;
  assign bus.HMASTER = hmaster_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: the driver applies one cycle of bus
// inputs and queues the outputs expected after the following rising edge; a
// negedge monitor pops and compares them.
module tb_ahb_bus_arbiter;
  localparam int N  = 4;
  localparam int MW = 2;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] INCR8  = 3'b101;
  localparam logic [2:0] INCR16 = 3'b111;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;

  ahb_bus_arbiter_if #(.NUM_MASTERS(N), .MW(MW)) bus ();

  ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0), .MW(MW)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int    cyc;
    string name;
    int    grant;
    int    master;
    int    lock;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic compare(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  task automatic check_outputs(input exp_t e);
    if (e.grant  >= 0) compare({e.name, ".HGRANT"},    int'(bus.HGRANT),    e.grant);
    if (e.master >= 0) compare({e.name, ".HMASTER"},   int'(bus.HMASTER),   e.master);
    if (e.lock   >= 0) compare({e.name, ".HMASTLOCK"}, int'(bus.HMASTLOCK), e.lock);
  endtask

  // Monitor: compare every expectation whose target cycle has arrived.
  always @(negedge HCLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      check_outputs(mon_e);
    end
  end

  task automatic step(input string nm, input logic [3:0] req, input logic [3:0] lck,
                      input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                      input logic rsp, input int eg, input int em, input int el);
    exp_t e;
    bus.HBUSREQ = req;
    bus.HLOCK   = lck;
    bus.HTRANS  = tr;
    bus.HBURST  = bu;
    bus.HREADY  = rdy;
    bus.HRESP   = rsp;
    e.cyc    = cyc + 1;
    e.name   = nm;
    e.grant  = eg;
    e.master = em;
    e.lock   = el;
    sb.push_back(e);
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.HBUSREQ = '0;
    bus.HLOCK   = '0;
    bus.HTRANS  = IDLE;
    bus.HBURST  = SINGLE;
    bus.HREADY  = 1'b1;
    bus.HRESP   = 1'b0;
  endtask

  task automatic direct_check(input string nm, input int eg, input int em, input int el);
    exp_t e;
    e.cyc = cyc; e.name = nm; e.grant = eg; e.master = em; e.lock = el;
    check_outputs(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    #12;
    direct_check("reset", 1, 0, 0);
    #10;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // parked on default master with no requests
    for (int k = 0; k < 20; k++) step("park", 4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 1, 0, 0);

    // round-robin between masters 1 and 2 with SINGLE transfers
    step("rr_a", 4'b0110, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0010, 0, 0);
    step("rr_b", 4'b0110, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0010, 1, 0);
    step("rr_c", 4'b0110, 4'b0000, NONSEQ, SINGLE, 1, 0, 4'b0100, 1, 0);
    step("rr_d", 4'b0110, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0100, 2, 0);
    step("rr_e", 4'b0110, 4'b0000, NONSEQ, SINGLE, 1, 0, 4'b0010, 2, 0);
    step("rr_f", 4'b0110, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0010, 1, 0);
    step("rr_g", 4'b0110, 4'b0000, NONSEQ, SINGLE, 1, 0, 4'b0100, 1, 0);
    step("rr_h", 4'b0110, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0100, 2, 0);

    // master 3 INCR8 while master 1 requests
    step("i8_g0", 4'b1000, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b1000, 2, 0);
    step("i8_g1", 4'b1000, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b1000, 3, 0);
    step("i8_ns", 4'b1010, 4'b0000, NONSEQ, INCR8,  1, 0, 4'b1000, 3, 0);
    for (int k = 0; k < 6; k++) step("i8_seq", 4'b1010, 4'b0000, SEQ, INCR8, 1, 0, 4'b1000, 3, 0);
    step("i8_last", 4'b1010, 4'b0000, SEQ,  INCR8,  1, 0, 4'b0010, 3, 0);
    step("i8_hand", 4'b0010, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0010, 1, 0);

    // master 1 INCR4 with wait states and a BUSY beat
    step("i4_ns",   4'b0110, 4'b0000, NONSEQ, INCR4, 1, 0, 4'b0010, 1, 0);
    for (int k = 0; k < 3; k++) step("i4_wait", 4'b0110, 4'b0000, SEQ, INCR4, 0, 0, 4'b0010, 1, 0);
    step("i4_b2",   4'b0110, 4'b0000, SEQ,  INCR4,  1, 0, 4'b0010, 1, 0);
    step("i4_busy", 4'b0110, 4'b0000, BUSY, INCR4,  1, 0, 4'b0010, 1, 0);
    step("i4_b3",   4'b0110, 4'b0000, SEQ,  INCR4,  1, 0, 4'b0010, 1, 0);
    step("i4_b4",   4'b0110, 4'b0000, SEQ,  INCR4,  1, 0, 4'b0100, 1, 0);
    step("i4_hold", 4'b0110, 4'b0000, IDLE, SINGLE, 0, 0, 4'b0100, 1, 0);
    step("i4_own",  4'b0110, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0100, 2, 0);

    // master 0 INCR16 aborted by ERROR on beat 3, master 2 waiting
    step("er_g0", 4'b0001, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0001, 2, 0);
    step("er_g1", 4'b0001, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0001, 0, 0);
    step("er_ns", 4'b0101, 4'b0000, NONSEQ, INCR16, 1, 0, 4'b0001, 0, 0);
    step("er_b2", 4'b0101, 4'b0000, SEQ,    INCR16, 1, 0, 4'b0001, 0, 0);
    step("er_b3", 4'b0101, 4'b0000, SEQ,    INCR16, 1, 1, 4'b0001, 0, 0);
    step("er_rg", 4'b0101, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0100, 0, 0);
    step("er_ow", 4'b0101, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0100, 2, 0);

    // reset pulse in the middle of a master 2 INCR8
    step("rs_ns", 4'b0100, 4'b0000, NONSEQ, INCR8, 1, 0, 4'b0100, 2, 0);
    step("rs_b2", 4'b0100, 4'b0000, SEQ,    INCR8, 1, 0, 4'b0100, 2, 0);
    step("rs_b3", 4'b0100, 4'b0000, SEQ,    INCR8, 1, 0, 4'b0100, 2, 0);
    @(negedge HCLK);
    #1;
    HRESETn = 1'b0;
    idle_inputs();
    #1;
    direct_check("rs_async", 1, 0, 0);
    @(posedge HCLK);
    @(negedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    step("rs_rq", 4'b0100, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0100, 0, 0);
    step("rs_ow", 4'b0100, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0100, 2, 0);

    // master 2 undefined-length burst released by dropping its request
    step("in_ns",  4'b0110, 4'b0000, NONSEQ, INCR,   1, 0, 4'b0100, 2, 0);
    step("in_sq",  4'b0110, 4'b0000, SEQ,    INCR,   1, 0, 4'b0100, 2, 0);
    step("in_rel", 4'b0010, 4'b0000, SEQ,    INCR,   1, 0, 4'b0010, 2, 0);
    step("in_end", 4'b0010, 4'b0000, IDLE,   SINGLE, 1, 0, 4'b0010, 1, 0);

    // no requests: park back on default master
    step("pk_a", 4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 1, 0);
    step("pk_b", 4'b0000, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0001, 0, 0);

`ifdef AHB_ARB_LOCK_EN
    // master 1 locked over two INCR4 bursts while master 2 requests
    step("lk_g",  4'b0010, 4'b0010, IDLE,   SINGLE, 1, 0, 4'b0010, 0, 0);
    step("lk_o",  4'b0110, 4'b0010, IDLE,   SINGLE, 1, 0, 4'b0010, 1, 1);
    for (int b = 0; b < 2; b++) begin
      step("lk_ns", 4'b0110, 4'b0010, NONSEQ, INCR4, 1, 0, 4'b0010, 1, 1);
      for (int k = 0; k < 3; k++) step("lk_sq", 4'b0110, 4'b0010, SEQ, INCR4, 1, 0, 4'b0010, 1, 1);
    end
    step("lk_rel", 4'b0110, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0100, 1, 1);
    step("lk_new", 4'b0110, 4'b0000, IDLE, SINGLE, 1, 0, 4'b0100, 2, 0);
`endif

    idle_inputs();
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge HCLK);
    @(negedge HCLK);
    #1;
    if (sb.size() != 0) compare("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
